sigma_delta_adc: RTL and testbench
==================================

Name: sigma_delta_adc

Overview:
- First-order delta-sigma ADC: the receive-direction counterpart of the team's delta-sigma DAC.
- Samples an external comparator bit (LVDS pair or a comparator fed by an RC integrator) and drives a 1-bit feedback pin that closes the loop through the RC network.
- A second-order CIC decimator converts the ones-density into an OUT_W-bit excess-2^(OUT_W-1) code, the same code format the DAC consumes.
- Used for audio/paddle input capture; digital loopback against the DAC is the primary self-test.

Parameters:
- OSR_LOG2, 7: log2 of decimation ratio R (R = 128 clocks per output sample).
- OUT_W, 13: output sample width; must satisfy OUT_W <= 2*OSR_LOG2.
- SYNC_STAGES, 2: comparator synchronizer depth (>= 2).

Ports:
- Clk  in  1  system clock; all logic rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  conversion enable, level-sensitive.
- CmpIn  in  1  raw asynchronous comparator output (1 = analog input above integrator voltage).
- FBout  out  1  feedback bit to RC network; registered, intended for IOB flop.
- Sample  out  OUT_W  latest decimated sample, excess-2^(OUT_W-1) code.
- SampleValid  out  1  one-cycle strobe; Sample updated in the same cycle.

Behaviour:
- Reset (async assert, sync deassert externally): sync chain, FBout, integrators, combs, decimation counter, prime counter all 0; Sample = 0; SampleValid = 0.
- Input path: CmpIn passes through SYNC_STAGES flops giving s. FBout <= s each enabled cycle, so FBout lags CmpIn by SYNC_STAGES+1 clocks.
- Integrators (width W = 2*OSR_LOG2+1, modulo 2^W wrap is intended, no saturation):
  - I1 <= I1 + s
  - I2 <= I2 + I1
- Decimation counter: 0..R-1, increments each enabled cycle; the cycle it equals R-1 is a boundary.
- At a boundary, combs registered:
  - C1 = I2 - I2d; I2d <= I2
  - C2 = C1 - C1d; C1d <= C1
  - All arithmetic is mod 2^W.
- Output:
  - Cycle after a boundary: full = C2, range 0..2^(2*OSR_LOG2).
  - full == 2^(2*OSR_LOG2) saturates to 2^(2*OSR_LOG2)-1.
  - Sample = full >> (2*OSR_LOG2 - OUT_W).
- Priming:
  - The first 2 boundaries after reset or after Enable rises only load comb state; Sample and SampleValid are untouched.
  - The 3rd and every later boundary produces SampleValid = 1 for one cycle.
  - Steady-state SampleValid period is exactly R clocks.
- Enable low:
  - Sync chain keeps running.
  - FBout, integrators, combs and counter hold.
  - SampleValid = 0; Sample holds its last value.
  - Enable rising restarts priming and clears the counter to 0. Integrators keep their values; the combs remove them.
- Enable falling in the same cycle as a boundary: that boundary is discarded, with no strobe.
- Reset mid-conversion: immediate clear per the reset list above; the next valid sample arrives 3*R+1 enabled clocks after Reset_n deasserts.
- Code mapping: all-zero density gives 0; 50% density gives 2^(OUT_W-1); all-ones density gives 2^OUT_W-1.

Decomposition:
- Shared package (sd_pkg):
  - OSR_LOG2 and OUT_W defaults.
  - Derived CIC width W = 2*OSR_LOG2+1.
  - Excess-code midscale constant 2^(OUT_W-1), shared with the DAC.
- One natural sub-module, sd_cic2_decimator:
  - Contains the integrators, decimation counter, combs, priming and output scaling.
  - Inputs: bit, enable. Outputs: sample, valid.
  - The top level holds the synchronizer, FBout flop and Enable edge detect.

Test Plan:
- CmpIn held 1 after reset, Enable = 1 -> first SampleValid at clock 3*128+1 (+sync delay); Sample = 8191 (saturated); FBout = 1.
- CmpIn held 0 -> Sample = 0 on every strobe; FBout = 0.
- CmpIn toggling 1,0,1,0 each clock -> Sample = 4096 every strobe; strobes spaced exactly 128 clocks.
- Digital loopback: team delta-sigma DAC with DACin = 0x0C00 drives CmpIn -> steady-state Sample = 0x0C00 +/-2; repeat with 0x0001 and 0x1FFF.
- Enable dropped for 50 clocks mid-period with CmpIn = 1 -> no strobes while low; FBout frozen; after re-enable, 2 periods with no strobe, then Sample = 8191.
- Reset_n pulsed low mid-period -> all outputs 0 asynchronously; the post-reset strobe schedule matches the first scenario.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared delta-sigma definitions: default oversampling, output width, CIC width and
// the excess-code midscale used by both the ADC and the DAC.
package sd_pkg;

  localparam int OSR_LOG2_DEF = 7;
  localparam int OUT_W_DEF    = 13;
  localparam int CIC_W_DEF    = 2 * OSR_LOG2_DEF + 1;

  localparam logic [OUT_W_DEF-1:0] EXCESS_MID = {1'b1, {(OUT_W_DEF-1){1'b0}}};

  function automatic int cicWidth(input int osrLog2);
    return 2 * osrLog2 + 1;
  endfunction

endpackage

// File: rtl/sd_cic2_decimator.sv
// Second-order CIC decimator: turns a 1-bit ones-density stream into an excess-coded
// sample once every 2^OSR_LOG2 enabled clocks, after two priming boundaries.
module sd_cic2_decimator
  import sd_pkg::*;
#(
  parameter int OSR_LOG2 = OSR_LOG2_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             Restart,
  input  logic             DataBit,
  output logic [OUT_W-1:0] Sample,
  output logic             Valid
);

  localparam int W      = cicWidth(OSR_LOG2);
  localparam int FULL_W = 2 * OSR_LOG2;
  localparam int SHIFT  = FULL_W - OUT_W;

  localparam logic [1:0] PRIME_FIRST  = 2'd0;
  localparam logic [1:0] PRIME_SECOND = 2'd1;
  localparam logic [1:0] PRIME_DONE   = 2'd2;

  logic [OSR_LOG2-1:0] decCount;
  logic [OSR_LOG2-1:0] countNow;
  logic [1:0]          primeState;
  logic [1:0]          primeNow;
  logic                boundary;
  logic                outPending;

  logic [W-1:0] integ1;
  logic [W-1:0] integ2;
  logic [W-1:0] integ2Dly;
  logic [W-1:0] comb1Dly;
  logic [W-1:0] comb2;
  logic [W-1:0] comb1Next;
  logic [W-1:0] comb2Next;

  logic [FULL_W-1:0] fullSat;
  logic [FULL_W-1:0] fullShifted;

  // A restart makes this cycle behave as the first of a fresh conversion.
  always_comb begin
    countNow  = Restart ? '0 : decCount;
    primeNow  = Restart ? PRIME_FIRST : primeState;
    boundary  = Enable && (countNow == {OSR_LOG2{1'b1}});
    comb1Next = integ2 - integ2Dly;
    comb2Next = comb1Next - comb1Dly;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      integ1   <= '0;
      integ2   <= '0;
      decCount <= '0;
    end else if (Enable) begin
      integ1   <= integ1 + W'(DataBit);
      integ2   <= integ2 + integ1;
      decCount <= countNow + 1'b1;
    end
  end

  // Combs always load at a boundary; only a primed boundary hands a result onward.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      integ2Dly  <= '0;
      comb1Dly   <= '0;
      comb2      <= '0;
      primeState <= PRIME_FIRST;
      outPending <= 1'b0;
    end else begin
      outPending <= boundary && (primeNow == PRIME_DONE);
      if (Enable) begin
        primeState <= primeNow;
      end
      if (boundary) begin
        integ2Dly <= integ2;
        comb1Dly  <= comb1Next;
        if (primeNow == PRIME_DONE) begin
          comb2 <= comb2Next;
        end else begin
          primeState <= primeNow + 2'd1;
        end
      end
    end
  end

  // Only full scale sets the top comb bit, so it selects saturation.
  always_comb begin
    fullSat     = comb2[FULL_W] ? {FULL_W{1'b1}} : comb2[FULL_W-1:0];
    fullShifted = fullSat >> SHIFT;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Sample <= '0;
      Valid  <= 1'b0;
    end else if (outPending && Enable) begin
      Sample <= fullShifted[OUT_W-1:0];
      Valid  <= 1'b1;
    end else begin
      Valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/sigma_delta_adc.sv
// First-order delta-sigma ADC front end: comparator synchronizer, registered feedback
// bit and enable edge detect, feeding the CIC decimator.
module sigma_delta_adc
  import sd_pkg::*;
#(
  parameter int OSR_LOG2    = OSR_LOG2_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             CmpIn,
  output logic             FBout,
  output logic [OUT_W-1:0] Sample,
  output logic             SampleValid
);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   cmpSync;
  logic                   enablePrev;
  logic                   restart;

  // The synchronizer runs regardless of Enable so the first enabled bit is settled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      syncChain <= '0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], CmpIn};
    end
  end

  assign cmpSync = syncChain[SYNC_STAGES-1];
  assign restart = Enable && !enablePrev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      FBout      <= 1'b0;
      enablePrev <= 1'b0;
    end else begin
      enablePrev <= Enable;
      if (Enable) begin
        FBout <= cmpSync;
      end
    end
  end

  sd_cic2_decimator #(
    .OSR_LOG2 (OSR_LOG2),
    .OUT_W    (OUT_W)
  ) decimator (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Enable  (Enable),
    .Restart (restart),
    .DataBit (cmpSync),
    .Sample  (Sample),
    .Valid   (SampleValid)
  );

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc: fixed densities, toggling input, DAC loopback,
// enable gaps and mid-conversion reset, all against hand-computed values.
module tb_sigma_delta_adc;
  import sd_pkg::*;

  localparam int R          = 128;
  localparam int FIRST_LAT  = 3 * R + 1;
  localparam int FULL_CODE  = 8191;

  logic        Clk     = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Enable  = 1'b0;
  logic        CmpIn   = 1'b0;
  logic        FBout;
  logic [12:0] Sample;
  logic        SampleValid;

  int compareCount  = 0;
  int mismatchCount = 0;

  int          stimMode  = 0;
  logic        stimLevel = 1'b0;
  logic [12:0] dacIn     = '0;
  logic [13:0] dacAcc    = '0;
  logic        toggleBit = 1'b0;

  sigma_delta_adc dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Enable      (Enable),
    .CmpIn       (CmpIn),
    .FBout       (FBout),
    .Sample      (Sample),
    .SampleValid (SampleValid)
  );

  always #5 Clk = ~Clk;

  // Comparator source: constant level, alternating bits, or a first-order DAC model.
  always @(negedge Clk) begin
    case (stimMode)
      0: CmpIn = stimLevel;
      1: begin
        toggleBit = ~toggleBit;
        CmpIn = toggleBit;
      end
      default: begin
        dacAcc = {1'b0, dacAcc[12:0]} + {1'b0, dacIn};
        CmpIn = dacAcc[13];
      end
    endcase
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int mode, input logic level, input logic en,
                               input logic [12:0] din);
    stimMode  = mode;
    stimLevel = level;
    Enable    = en;
    dacIn     = din;
  endtask

  task automatic applyReset();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Returns the number of rising edges until SampleValid is seen, or -1 on timeout.
  task automatic waitStrobe(input int budget, output int cycles);
    bit hit;
    hit = 1'b0;
    cycles = -1;
    for (int i = 1; i <= budget && !hit; i++) begin
      @(posedge Clk);
      #1;
      if (SampleValid) begin
        hit = 1'b1;
        cycles = i;
      end
    end
  endtask

  task automatic runLoopback(input string tag, input logic [12:0] din);
    int cycles;
    int sum;
    int avg;
    int diff;
    applyStimulus(2, 1'b0, 1'b1, din);
    for (int k = 0; k < 3; k++) waitStrobe(2 * R, cycles);
    sum = 0;
    for (int k = 0; k < 64; k++) begin
      waitStrobe(2 * R, cycles);
      if (cycles < 0) sum = sum - 100000;
      sum = sum + int'(Sample);
    end
    avg  = (sum + 32) / 64;
    diff = avg - int'(din);
    if (diff < 0) diff = -diff;
    if (diff > 2) $display("[TB] %s average %0d for code %0d", tag, avg, din);
    checkOutput(tag, (diff <= 2) ? 1 : 0, 1);
  endtask

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int strobes;

    #2 Reset_n = 1'b0;
    #1;
    checkOutput("reset_sample", int'(Sample), 0);
    checkOutput("reset_valid", int'(SampleValid), 0);
    checkOutput("reset_fbout", int'(FBout), 0);

    // All ones: first strobe after three periods plus the output register, saturated.
    applyStimulus(0, 1'b1, 1'b1, '0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    waitStrobe(FIRST_LAT + 10, cycles);
    checkOutput("ones_first_latency", cycles, FIRST_LAT);
    checkOutput("ones_first_sample", int'(Sample), FULL_CODE);
    checkOutput("ones_fbout", int'(FBout), 1);
    waitStrobe(2 * R, cycles);
    checkOutput("ones_period", cycles, R);
    checkOutput("ones_second_sample", int'(Sample), FULL_CODE);
    @(posedge Clk); #1;
    checkOutput("ones_valid_one_cycle", int'(SampleValid), 0);

    // All zeros.
    applyStimulus(0, 1'b0, 1'b1, '0);
    applyReset();
    waitStrobe(FIRST_LAT + 10, cycles);
    checkOutput("zeros_first_latency", cycles, FIRST_LAT);
    for (int k = 0; k < 3; k++) begin
      checkOutput("zeros_sample", int'(Sample), 0);
      waitStrobe(2 * R, cycles);
    end
    checkOutput("zeros_fbout", int'(FBout), 0);

    // Alternating bits: 50% density lands on midscale.
    applyStimulus(1, 1'b0, 1'b1, '0);
    applyReset();
    waitStrobe(FIRST_LAT + 10, cycles);
    checkOutput("toggle_first_latency", cycles, FIRST_LAT);
    checkOutput("toggle_first_sample", int'(Sample), int'(EXCESS_MID));
    for (int k = 0; k < 3; k++) begin
      waitStrobe(2 * R, cycles);
      checkOutput("toggle_period", cycles, R);
      checkOutput("toggle_sample", int'(Sample), 4096);
    end

    // Digital loopback through a first-order DAC model.
    runLoopback("loop_0C00", 13'h0C00);
    runLoopback("loop_0001", 13'h0001);
    runLoopback("loop_1FFF", 13'h1FFF);

    // Enable gap mid-period: no strobes, outputs frozen, then re-priming.
    applyStimulus(0, 1'b1, 1'b1, '0);
    applyReset();
    waitStrobe(FIRST_LAT + 10, cycles);
    checkOutput("gap_prelude_latency", cycles, FIRST_LAT);
    repeat (40) @(posedge Clk);
    #1;
    applyStimulus(0, 1'b0, 1'b0, '0);
    strobes = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge Clk); #1;
      if (SampleValid) strobes++;
      if (k == 40) stimLevel = 1'b1;
    end
    checkOutput("gap_no_strobes", strobes, 0);
    checkOutput("gap_fbout_frozen", int'(FBout), 1);
    checkOutput("gap_sample_held", int'(Sample), FULL_CODE);
    applyStimulus(0, 1'b1, 1'b1, '0);
    waitStrobe(FIRST_LAT + 10, cycles);
    checkOutput("gap_reprime_latency", cycles, FIRST_LAT);
    checkOutput("gap_reprime_sample", int'(Sample), FULL_CODE);

    // Asynchronous reset mid-period.
    repeat (60) @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    checkOutput("midreset_sample", int'(Sample), 0);
    checkOutput("midreset_valid", int'(SampleValid), 0);
    checkOutput("midreset_fbout", int'(FBout), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    waitStrobe(FIRST_LAT + 10, cycles);
    checkOutput("midreset_latency", cycles, FIRST_LAT);
    checkOutput("midreset_sample_after", int'(Sample), FULL_CODE);
    waitStrobe(2 * R, cycles);
    checkOutput("midreset_period", cycles, R);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
